// File: rtl/rr_arbiter4.sv
// rr_arbiter4: four-requester round-robin arbiter with a two-state FSM.
// A grant is held until its owner drops req. After every release there is
// a one-cycle bubble in which nobody is granted.
// Optional feature macro: ARB_TIMEOUT_EN adds a hold counter. The counter
// forces a release after HOLD_MAX grant cycles and pulses timeout for one
// cycle when it does.
module rr_arbiter4 #(
  parameter int HOLD_MAX = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic [1:0] grant_idx,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // Elaboration-time guard: a hold limit below 2 makes the forced release meaningless.
  if (HOLD_MAX < 2) begin : g_bad_hold_max
    $error("rr_arbiter4: HOLD_MAX must be at least 2");
  end

  // Rotating priority scan: first set request starting just after last_v.
  function automatic logic [1:0] rr_pick(input logic [3:0] req_v, input logic [1:0] last_v);
    logic [1:0] cand;
    logic       found;
    rr_pick = last_v;
    found   = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cand = last_v + 2'(k);
      if (!found && req_v[cand]) begin
        rr_pick = cand;
        found   = 1'b1;
      end else begin
        found   = found;
      end
    end
  endfunction

  // One-hot decode of a two-bit index.
  function automatic logic [3:0] idx_decode(input logic [1:0] idx_v);
    idx_decode = 4'b0001 << idx_v;
  endfunction

  state_t     state_r;
  state_t     state_nxt_s;
  logic [3:0] grant_r;
  logic [3:0] grant_nxt_s;
  logic [1:0] grant_idx_r;
  logic [1:0] grant_idx_nxt_s;
  logic       busy_r;
  logic       busy_nxt_s;
  logic [1:0] last_idx_r;
  logic [1:0] last_idx_nxt_s;
  logic [1:0] winner_s;
  logic       any_req_s;
  logic       owner_req_s;
  logic       hold_expire_s;
  logic       release_s;
  logic       new_grant_s;

  assign winner_s    = rr_pick(req, last_idx_r);
  assign any_req_s   = |req;
  assign owner_req_s = req[grant_idx_r];

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = (HOLD_MAX > 2) ? $clog2(HOLD_MAX) : 1;

  logic [CNT_W-1:0] hold_cnt_r;
  logic             timeout_r;

  // The owner has used up its allowed hold time on this edge.
  assign hold_expire_s = (state_r == ST_GRANT) && (hold_cnt_r == CNT_W'(HOLD_MAX - 1));

  // Hold counter: cleared on every new grant, counts each grant cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt_r <= '0;
      timeout_r  <= 1'b0;
    end else begin
      timeout_r <= hold_expire_s;
      if (new_grant_s || release_s) begin
        hold_cnt_r <= '0;
      end else if (state_r == ST_GRANT) begin
        hold_cnt_r <= hold_cnt_r + CNT_W'(1);
      end else begin
        hold_cnt_r <= hold_cnt_r;
      end
    end
  end

  assign timeout = timeout_r;
`else
  // Without the hold limit a grant lasts for as long as the owner keeps requesting.
  assign hold_expire_s = 1'b0;
  assign timeout       = 1'b0;
`endif

  // A release happens when the owner drops req, or when the hold limit forces it.
  assign release_s   = (state_r == ST_GRANT) && (!owner_req_s || hold_expire_s);
  assign new_grant_s = (state_r == ST_IDLE) && any_req_s;

  // State register together with the registered outputs and the priority pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      grant_r     <= 4'b0000;
      grant_idx_r <= 2'b00;
      busy_r      <= 1'b0;
      last_idx_r  <= 2'b11;
    end else begin
      state_r     <= state_nxt_s;
      grant_r     <= grant_nxt_s;
      grant_idx_r <= grant_idx_nxt_s;
      busy_r      <= busy_nxt_s;
      last_idx_r  <= last_idx_nxt_s;
    end
  end

  // Next-state logic: IDLE waits for any request; GRANT waits for a release.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (any_req_s) begin
          state_nxt_s = ST_GRANT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (release_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_GRANT;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Output logic: load a new index on a grant, and record the owner on a release.
  always_comb begin
    grant_idx_nxt_s = grant_idx_r;
    last_idx_nxt_s  = last_idx_r;
    case (state_r)
      ST_IDLE: begin
        if (any_req_s) begin
          grant_idx_nxt_s = winner_s;
        end else begin
          grant_idx_nxt_s = grant_idx_r;
        end
      end
      ST_GRANT: begin
        if (release_s) begin
          last_idx_nxt_s = grant_idx_r;
        end else begin
          last_idx_nxt_s = last_idx_r;
        end
      end
      default: begin
        grant_idx_nxt_s = grant_idx_r;
        last_idx_nxt_s  = last_idx_r;
      end
    endcase
    busy_nxt_s = (state_nxt_s == ST_GRANT);
    if (busy_nxt_s) begin
      grant_nxt_s = idx_decode(grant_idx_nxt_s);
    end else begin
      grant_nxt_s = 4'b0000;
    end
  end

  assign grant     = grant_r;
  assign grant_idx = grant_idx_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Self-checking bench for rr_arbiter4: a directed vector table, hand-written
// multi-cycle sequences and a randomized run against a behavioural model.
module tb_rr_arbiter4;

  localparam int HOLD = 8;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] grant;
  logic [1:0] grant_idx;
  logic       busy;
  logic       timeout;

  int checks;
  int failures;

  rr_arbiter4 #(.HOLD_MAX(HOLD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .grant     (grant),
    .grant_idx (grant_idx),
    .busy      (busy),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] idx;
    logic       busy;
    logic       to;
  } vec_t;

  vec_t tbl [19];

  // Behavioural model state
  bit       m_busy;
  int       m_idx;
  int       m_last;
  int       m_hold;
  bit       m_to;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got {grant,idx,busy,to}=%b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] outs();
    return {grant, grant_idx, busy, timeout};
  endfunction

  function automatic logic [7:0] pack_exp(input logic [3:0] g, input logic [1:0] i,
                                          input logic b, input logic t);
    return {g, i, b, t};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = 4'b0000;
    #1;
    chk("reset_state", outs(), 8'b0000_00_0_0);
    @(negedge clk);
    rst_n  = 1'b1;
    m_busy = 1'b0;
    m_idx  = 0;
    m_last = 3;
    m_hold = 0;
    m_to   = 1'b0;
  endtask

  // Model: apply one clock edge that samples req_v.
  task automatic model_step(input logic [3:0] req_v);
    bit expire;
    m_to = 1'b0;
    if (!m_busy) begin
      if (req_v != 4'b0000) begin
        for (int k = 1; k <= 4; k++) begin
          if (!m_busy && req_v[(m_last + k) % 4]) begin
            m_idx  = (m_last + k) % 4;
            m_busy = 1'b1;
            m_hold = 0;
          end
        end
      end
    end else begin
      expire = TO_EN && (m_hold == HOLD - 1);
      if (!req_v[m_idx] || expire) begin
        m_busy = 1'b0;
        m_last = m_idx;
        m_to   = expire;
        m_hold = 0;
      end else begin
        m_hold = m_hold + 1;
      end
    end
  endtask

  function automatic logic [7:0] model_exp();
    logic [3:0] g;
    logic [1:0] i;
    i = 2'(m_idx);
    g = m_busy ? (4'b0001 << i) : 4'b0000;
    return {g, i, m_busy, m_to};
  endfunction

  initial begin
    logic [3:0] r;
    logic [3:0] oh;
    checks   = 0;
    failures = 0;
    rst_n    = 1'b1;
    req      = 4'b0000;

    // Directed table: {req driven before the edge, expected outputs after it}
    tbl[0]  = '{4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0};
    tbl[1]  = '{4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0};
    tbl[2]  = '{4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0};
    tbl[3]  = '{4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0};
    tbl[4]  = '{4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0};
    tbl[5]  = '{4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0};
    tbl[6]  = '{4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0};
    tbl[7]  = '{4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0};
    tbl[8]  = '{4'b1011, 4'b0010, 2'd1, 1'b1, 1'b0};
    tbl[9]  = '{4'b1011, 4'b0010, 2'd1, 1'b1, 1'b0};
    tbl[10] = '{4'b1001, 4'b0000, 2'd1, 1'b0, 1'b0};
    tbl[11] = '{4'b1001, 4'b1000, 2'd3, 1'b1, 1'b0};
    tbl[12] = '{4'b0000, 4'b0000, 2'd3, 1'b0, 1'b0};
    tbl[13] = '{4'b1111, 4'b0001, 2'd0, 1'b1, 1'b0};
    tbl[14] = '{4'b1110, 4'b0000, 2'd0, 1'b0, 1'b0};
    tbl[15] = '{4'b1110, 4'b0010, 2'd1, 1'b1, 1'b0};
    tbl[16] = '{4'b1111, 4'b0010, 2'd1, 1'b1, 1'b0};
    tbl[17] = '{4'b1101, 4'b0000, 2'd1, 1'b0, 1'b0};
    tbl[18] = '{4'b1111, 4'b0100, 2'd2, 1'b1, 1'b0};

    do_reset();
    for (int i = 0; i < 19; i++) begin
      req = tbl[i].req;
      tick();
      chk($sformatf("table_%0d", i), outs(),
          pack_exp(tbl[i].grant, tbl[i].idx, tbl[i].busy, tbl[i].to));
    end

    // Rotation from reset with all four requesting; each owner drops for one cycle
    // after three grant cycles.
    @(negedge clk);
    rst_n = 1'b0;
    req   = 4'b1111;
    @(negedge clk);
    rst_n = 1'b1;
    for (int g = 0; g < 5; g++) begin
      oh = 4'b0001 << (g % 4);
      for (int c = 0; c < 3; c++) begin
        tick();
        chk($sformatf("rot_grant_%0d_%0d", g, c), outs(), pack_exp(oh, 2'(g % 4), 1'b1, 1'b0));
      end
      req = 4'b1111 & ~oh;
      tick();
      chk($sformatf("rot_bubble_%0d", g), outs(), pack_exp(4'b0000, 2'(g % 4), 1'b0, 1'b0));
      req = 4'b1111;
    end

    // Asynchronous reset in the middle of a grant.
    do_reset();
    req = 4'b0100;
    tick();
    chk("pre_async_grant", outs(), pack_exp(4'b0100, 2'd2, 1'b1, 1'b0));
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_mid_grant", outs(), 8'b0000_00_0_0);
    @(negedge clk);
    rst_n = 1'b1;
    req   = 4'b1010;
    tick();
    chk("post_reset_1010", outs(), pack_exp(4'b0010, 2'd1, 1'b1, 1'b0));

    // Single requester held: forced release with the timeout feature, unbounded otherwise.
    do_reset();
    req = 4'b0001;
    if (TO_EN) begin
      for (int c = 0; c < HOLD; c++) begin
        tick();
        chk($sformatf("hold_grant_%0d", c), outs(), pack_exp(4'b0001, 2'd0, 1'b1, 1'b0));
      end
      tick();
      chk("hold_timeout_pulse", outs(), pack_exp(4'b0000, 2'd0, 1'b0, 1'b1));
      tick();
      chk("hold_regrant", outs(), pack_exp(4'b0001, 2'd0, 1'b1, 1'b0));
    end else begin
      for (int c = 0; c < 3 * HOLD; c++) begin
        tick();
        chk($sformatf("hold_forever_%0d", c), outs(), pack_exp(4'b0001, 2'd0, 1'b1, 1'b0));
      end
    end

    // Randomized traffic against the model.
    do_reset();
    r = 4'b0000;
    for (int n = 0; n < 1500; n++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 3) == 0) r[b] = ~r[b];
      end
      req = r;
      tick();
      model_step(r);
      chk($sformatf("random_%0d", n), outs(), model_exp());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rr_arbiter4.md
RR_ARBITER4 -- requirements
Module: rr_arbiter4

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named clk and rst_n.
REQ-002 Parameter HOLD_MAX, default 8: maximum GRANT cycles before a forced release (used only with ARB_TIMEOUT_EN).
REQ-003 Port clk, input, 1: rising-edge clock for all state.
REQ-004 Port rst_n, input, 1: asynchronous active-low reset.
REQ-005 Port req, input, 4: request lines; bit i is requester i.
REQ-006 Port grant, output, 4: registered one-hot grant; bit i grants requester i.
REQ-007 Port grant_idx, output, 2: registered binary index of the current or last granted requester.
REQ-008 Port busy, output, 1: high while the state is GRANT.
REQ-009 Port timeout, output, 1: one-cycle pulse on a forced release.

Function
REQ-010 The block SHALL implement two states, IDLE and GRANT.
REQ-011 In IDLE with req==0, the state SHALL stay IDLE, with grant=0 and busy=0.
REQ-012 In IDLE with req!=0 at an edge, the winner SHALL be the first set req bit scanning (last_idx+1) mod 4, +2, +3, +4 (wrap-around); that edge SHALL load grant_idx=winner, set busy=1, set the state to GRANT.
REQ-013 Request-to-grant latency SHALL be 1 cycle: grant is visible after the edge that sampled req.
REQ-014 grant SHALL always equal the 2-to-4 decode of grant_idx when busy=1, and 0000 when busy=0; at most one bit is ever set.
REQ-015 In GRANT, the grant SHALL hold while req[grant_idx]=1; changes on other req bits SHALL be ignored (no preemption).
REQ-016 In GRANT, an edge sampling req[grant_idx]=0 SHALL set last_idx=grant_idx, clear grant and busy, and set the state to IDLE.
REQ-017 After any release, the next grant SHALL appear no earlier than 1 further edge, giving a mandatory one-cycle bubble with grant=0000 between grants.
REQ-018 A requester that drops and re-raises req during the bubble SHALL be arbitrated normally; it has the lowest priority because last_idx equals its index.
REQ-019 The rotation SHALL guarantee that, with all four requesting continuously, grants follow the order 0,1,2,3,0,... from reset.
REQ-020 grant_idx SHALL retain its value in IDLE; it SHALL change only when a new grant is issued.

Reset
REQ-021 Asserting rst_n=0 SHALL immediately, independent of clk, force grant=0000, grant_idx=00, busy=0, timeout=0, state=IDLE, last_idx=3 and hold counter=0, including mid-grant.
REQ-022 After deassertion, the first arbitration SHALL give requester 0 highest priority.

Configuration
REQ-023 Macro ARB_TIMEOUT_EN, when defined, SHALL include a hold counter that is cleared on grant and increments each GRANT cycle.
REQ-024 With ARB_TIMEOUT_EN, the edge at which the counter equals HOLD_MAX-1 SHALL force release (as REQ-016) even if req[grant_idx]=1, and SHALL pulse timeout=1 for exactly one cycle.
REQ-025 With ARB_TIMEOUT_EN, a requester still requesting after a forced release SHALL re-enter arbitration with the lowest priority.
REQ-026 Without ARB_TIMEOUT_EN, the block SHALL contain no counter, timeout SHALL be tied to 0, and grant hold SHALL be unbounded.

Verification
REQ-027 Reset with req=1111 held, then release rst_n -> grants 0001,(bubble),0010,(bubble),0100,(bubble),1000,(bubble),0001, with each requester dropping req for one cycle after 3 grant cycles.
REQ-028 Single req=0100 held 5 cycles, then dropped -> grant=0100 and grant_idx=10 from cycle 1 through 5, then grant=0000 and busy=0, with grant_idx still 10.
REQ-029 In GRANT on requester 1, raise req[0] and req[3] -> no grant change until req[1] drops; next grant=1000 (idx 3 precedes 0 after 1).
REQ-030 Assert rst_n=0 mid-grant between clock edges -> grant=0000 and busy=0 immediately; after release, req=1010 -> grant=0010.
REQ-031 With ARB_TIMEOUT_EN and HOLD_MAX=8, hold req=0001 -> grant high 8 cycles, timeout=1 for 1 cycle, bubble, re-grant 0001; without the macro -> grant held indefinitely and timeout=0.
